// File: rtl/phase_dwell_scheduler.sv
// Dwell timer beside the traffic-light FSM: strobes its clock enable
// on max-out, gap-out of an extended green, or an illegal state code.
module phase_dwell_scheduler #(
    parameter int CNT_W      = 8,
    parameter int T_PRIMARY  = 20,
    parameter int T_EXTENDED = 40,
    parameter int T_YELLOW   = 4,
    parameter int T_ALL_RED  = 2,
    parameter int T_GAP      = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             enable,
    input  logic [3:0]       fsm_state,
    input  logic [3:0]       demand,
    output logic             advance,
    output logic             gap_out,
    output logic [CNT_W-1:0] remaining,
    output logic             phase_err
);

    localparam logic [1:0] S_LOAD = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIRE = 2'd2;

    localparam logic [CNT_W-1:0] DUR_PRI = CNT_W'(T_PRIMARY);
    localparam logic [CNT_W-1:0] DUR_EXT = CNT_W'(T_EXTENDED);
    localparam logic [CNT_W-1:0] DUR_YEL = CNT_W'(T_YELLOW);
    localparam logic [CNT_W-1:0] DUR_RED = CNT_W'(T_ALL_RED);
    localparam logic [CNT_W-1:0] GAP_MAX = CNT_W'(T_GAP);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    logic [1:0]       state_q, state_d;
    logic [3:0]       last_q, last_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] gap_q, gap_d;
    logic             gout_q, gout_d;
    logic             perr_q, perr_d;

    logic [CNT_W-1:0] dur_sel;
    logic             is_ext, is_red, is_bad, own_dem;
    logic             cnt_zero, gap_zero;
    logic             fire_max, fire_gap, fire_any;
    logic             cnt_en;

    // Phase class and its dwell, straight from the FSM code.
    always_comb begin
        dur_sel = '0;
        is_ext  = 1'b0;
        is_red  = 1'b0;
        is_bad  = 1'b0;
        case (fsm_state)
            4'd0: begin
                dur_sel = DUR_RED;
                is_red  = 1'b1;
            end
            4'd1, 4'd4, 4'd7, 4'd10: dur_sel = DUR_PRI;
            4'd2, 4'd5, 4'd8, 4'd11: begin
                dur_sel = DUR_EXT;
                is_ext  = 1'b1;
            end
            4'd3, 4'd6, 4'd9, 4'd12: dur_sel = DUR_YEL;
            default: is_bad = 1'b1;
        endcase
    end

    always_comb begin
        case (fsm_state)
            4'd1, 4'd2, 4'd3:    own_dem = demand[0];
            4'd4, 4'd5, 4'd6:    own_dem = demand[1];
            4'd7, 4'd8, 4'd9:    own_dem = demand[2];
            4'd10, 4'd11, 4'd12: own_dem = demand[3];
            default:             own_dem = 1'b0;
        endcase
    end

    assign cnt_zero = (cnt_q == '0);
    assign gap_zero = (gap_q == '0);
    assign cnt_en   = enable & tick;

    // ALL_RED only times out once someone is waiting.
    assign fire_max = cnt_zero & (~is_red | (|demand));
    assign fire_gap = is_ext & gap_zero;
    assign fire_any = fire_max | fire_gap | is_bad;

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        gap_d   = gap_q;
        gout_d  = gout_q;
        perr_d  = perr_q | is_bad;
        case (state_q)
            S_LOAD: begin
                last_d  = fsm_state;
                cnt_d   = dur_sel;
                gap_d   = GAP_MAX;
                gout_d  = 1'b0;
                state_d = S_RUN;
            end
            S_RUN: begin
                if (fsm_state != last_q) begin
                    state_d = S_LOAD;
                end else if (enable && fire_any) begin
                    state_d = S_FIRE;
                    gout_d  = fire_gap & ~cnt_zero;
                end else begin
                    if (cnt_en && !cnt_zero) begin
                        cnt_d = cnt_q - ONE;
                    end
                    if (own_dem) begin
                        gap_d = GAP_MAX;
                    end else if (cnt_en && !gap_zero) begin
                        gap_d = gap_q - ONE;
                    end
                end
            end
            S_FIRE: state_d = S_LOAD;
            default: state_d = S_LOAD;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_LOAD;
            last_q  <= 4'd0;
            cnt_q   <= '0;
            gap_q   <= '0;
            gout_q  <= 1'b0;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            gap_q   <= gap_d;
            gout_q  <= gout_d;
            perr_q  <= perr_d;
        end
    end

    assign advance   = (state_q == S_FIRE);
    assign gap_out   = advance & gout_q;
    assign remaining = cnt_q;
    assign phase_err = perr_q;

endmodule

// File: tb/tb_phase_dwell_scheduler.sv
// Directed and randomized checks of phase_dwell_scheduler against a
// tick-counting model of each phase.
module tb_phase_dwell_scheduler;

    localparam int CNT_W = 8;
    localparam int TP    = 20;
    localparam int TE    = 40;
    localparam int TY    = 4;
    localparam int TR    = 2;
    localparam int TG    = 5;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             tick = 1'b0;
    logic             enable = 1'b0;
    logic [3:0]       fsm_state = 4'd0;
    logic [3:0]       demand = 4'd0;
    logic             advance, gap_out, phase_err;
    logic [CNT_W-1:0] remaining;
    logic             advance2, gap_out2, phase_err2;
    logic [CNT_W-1:0] remaining2;

    int errors = 0;
    int checks = 0;

    // Model: phase position plus ticks consumed and quiet ticks seen.
    int m_phase, m_code, m_dur, m_used, m_quiet;
    bit m_loaded, m_gout, m_perr;

    always #5 clk = ~clk;

    phase_dwell_scheduler #(
        .CNT_W(CNT_W), .T_PRIMARY(TP), .T_EXTENDED(TE),
        .T_YELLOW(TY), .T_ALL_RED(TR), .T_GAP(TG)
    ) u_dut (
        .clk(clk), .rst(rst), .tick(tick), .enable(enable),
        .fsm_state(fsm_state), .demand(demand),
        .advance(advance), .gap_out(gap_out),
        .remaining(remaining), .phase_err(phase_err)
    );

    phase_dwell_scheduler #(
        .CNT_W(CNT_W), .T_PRIMARY(TP), .T_EXTENDED(TG),
        .T_YELLOW(TY), .T_ALL_RED(TR), .T_GAP(TG)
    ) u_dut2 (
        .clk(clk), .rst(rst), .tick(tick), .enable(enable),
        .fsm_state(fsm_state), .demand(demand),
        .advance(advance2), .gap_out(gap_out2),
        .remaining(remaining2), .phase_err(phase_err2)
    );

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int dur_of(input int code);
        if (code == 0) return TR;
        if (code > 12) return 0;
        case ((code - 1) % 3)
            0: return TP;
            1: return TE;
            default: return TY;
        endcase
    endfunction

    function automatic bit is_ext(input int code);
        return code >= 1 && code <= 12 && ((code - 1) % 3) == 1;
    endfunction

    function automatic bit own_dem(input int code, input logic [3:0] d);
        if (code < 1 || code > 12) return 1'b0;
        return d[(code - 1) / 3];
    endfunction

    function automatic int exp_rem();
        if (!m_loaded) return 0;
        return (m_dur > m_used) ? m_dur - m_used : 0;
    endfunction

    task automatic model_reset();
        m_phase = 0; m_code = 0; m_dur = 0; m_used = 0; m_quiet = 0;
        m_loaded = 0; m_gout = 0; m_perr = 0;
    endtask

    task automatic model_step(input bit t, input bit e,
                              input logic [3:0] s, input logic [3:0] d);
        int rem;
        bit mx, gp;
        if (s >= 4'd13) m_perr = 1;
        if (m_phase == 0) begin
            m_code = int'(s); m_dur = dur_of(int'(s));
            m_used = 0; m_quiet = 0; m_loaded = 1; m_phase = 1;
        end else if (m_phase == 2) begin
            m_phase = 0;
        end else begin
            rem = exp_rem();
            mx  = (rem == 0) && (m_code != 0 || d != 4'd0);
            gp  = is_ext(m_code) && (m_quiet >= TG);
            if (int'(s) != m_code) begin
                m_phase = 0;
            end else if (e && (mx || gp || m_code >= 13)) begin
                m_phase = 2;
                m_gout  = gp && rem != 0;
            end else begin
                if (e && t && m_used < m_dur) m_used++;
                if (own_dem(m_code, d)) m_quiet = 0;
                else if (e && t && m_quiet < TG) m_quiet++;
            end
        end
    endtask

    // Called at a negedge; drives one cycle, then compares at the next negedge.
    task automatic cyc(input bit t, input bit e,
                       input logic [3:0] s, input logic [3:0] d);
        tick = t; enable = e; fsm_state = s; demand = d;
        @(posedge clk);
        model_step(t, e, s, d);
        @(negedge clk);
        check("m_adv", int'(advance), int'(m_phase == 2));
        check("m_gap_out", int'(gap_out), int'(m_phase == 2 && m_gout));
        check("m_remaining", int'(remaining), exp_rem());
        check("m_phase_err", int'(phase_err), int'(m_perr));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        check("rst_adv", int'(advance), 0);
        check("rst_gap_out", int'(gap_out), 0);
        check("rst_remaining", int'(remaining), 0);
        check("rst_phase_err", int'(phase_err), 0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        bit         seen;
        logic [3:0] s, d;
        bit         t, e;

        @(negedge clk);
        do_reset();

        // Yellow max-out: LOAD is cycle 0.
        check("y_rem_c0", int'(remaining), 0);
        for (int k = 1; k <= 7; k++) begin
            cyc(1, 1, 4'd3, 4'd0);
            check("y_rem", int'(remaining), (k <= TY) ? TY - k + 1 : 0);
            check("y_adv", int'(advance), int'(k == 6));
            check("y_gap_out", int'(gap_out), 0);
        end

        // Extended green gap-out after demand drops.
        do_reset();
        for (int k = 0; k < 10; k++) cyc(1, 1, 4'd8, 4'b0100);
        for (int i = 1; i <= 8; i++) begin
            cyc(1, 1, 4'd8, 4'b0000);
            check("g_adv", int'(advance), int'(i == 6));
            if (i == 6) begin
                check("g_gap_out", int'(gap_out), 1);
                check("g_rem_nonzero", int'(remaining > 0), 1);
            end
        end

        // Max-out and gap-out coincide on the second instance.
        do_reset();
        for (int i = 1; i <= 8; i++) begin
            cyc(1, 1, 4'd2, 4'd0);
            check("s_adv", int'(advance2), int'(i == 7));
            check("s_gap_out", int'(gap_out2), 0);
        end

        // ALL_RED holds without demand, then releases.
        do_reset();
        for (int i = 0; i < 50; i++) begin
            cyc(1, 1, 4'd0, 4'd0);
            check("r_adv_hold", int'(advance), 0);
        end
        check("r_rem_hold", int'(remaining), 0);
        cyc(1, 1, 4'd0, 4'b1000);
        check("r_adv_rel", int'(advance), 1);
        cyc(1, 1, 4'd0, 4'b1000);
        check("r_adv_once", int'(advance), 0);

        // Enable freeze, then external change of phase.
        do_reset();
        for (int k = 0; k < 11; k++) cyc(1, 1, 4'd1, 4'd0);
        check("f_rem_start", int'(remaining), 10);
        for (int k = 0; k < 20; k++) begin
            cyc(1, 0, 4'd1, 4'd0);
            check("f_rem_frozen", int'(remaining), 10);
            check("f_adv_frozen", int'(advance), 0);
        end
        cyc(1, 0, 4'd4, 4'd0);
        cyc(1, 0, 4'd4, 4'd0);
        check("f_rem_reload", int'(remaining), TP);

        // Illegal code, sticky error, reset mid-count.
        do_reset();
        seen = 0;
        for (int k = 0; k < 2; k++) begin
            cyc(1, 1, 4'd14, 4'd0);
            if (advance) seen = 1;
        end
        check("i_adv_within2", int'(seen), 1);
        check("i_phase_err", int'(phase_err), 1);
        for (int k = 0; k < 8; k++) cyc(1, 1, 4'd1, 4'd0);
        check("i_perr_sticky", int'(phase_err), 1);
        check("i_rem_midcount", int'(remaining > 0), 1);
        do_reset();

        // Randomized traffic with an FSM that follows the strobe.
        s = 4'd0;
        for (int n = 0; n < 3000; n++) begin
            t = ($urandom_range(0, 3) != 0);
            e = ($urandom_range(0, 19) != 0);
            d = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'd0;
            cyc(t, e, s, d);
            if (m_phase == 2) s = (s >= 4'd12) ? 4'd0 : s + 4'd1;
            else if ($urandom_range(0, 199) == 0) s = 4'($urandom_range(0, 12));
            else if ($urandom_range(0, 999) == 0) s = 4'($urandom_range(13, 15));
            if (n == 1500) begin
                @(negedge clk);
                do_reset();
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
